// File: rtl/bcd_display_scanner.sv
// Three-digit multiplexed 7-segment scanner for signed BCD results (-15..+15).
// Double-buffered input; display updates only at frame boundaries. Optional macro: LZ_BLANK_EN.
module bcd_display_scanner #(
   parameter int unsigned REFRESH_DIV    = 50000,
   parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [5:0] in_bcd,
   output logic       in_ready,
   output logic [6:0] seg,
   output logic [2:0] an
);

   localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   localparam logic [1:0] SLOT_ONES = 2'd0;
   localparam logic [1:0] SLOT_TENS = 2'd1;
   localparam logic [1:0] SLOT_SIGN = 2'd2;

   localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [2:0] AN_OFF  = SEG_ACTIVE_LOW ? 3'b111 : 3'b000;

   logic [1:0]       slot_q, slot_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [5:0]       shadow_q, shadow_d;
   logic [5:0]       disp_q, disp_d;
   logic             ready_q, ready_d;
   logic [6:0]       seg_q, seg_d;
   logic [2:0]       an_q, an_d;
   logic             frame_end;
   logic [6:0]       digit;
   logic [2:0]       an_raw;

   // Ones digit: codes 10..15 cannot occur in valid BCD and show 'E'.
   function automatic logic [6:0] ones_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h79;
      endcase
      return s;
   endfunction

   function automatic logic [6:0] tens_seg(input logic t);
      logic [6:0] s;
`ifdef LZ_BLANK_EN
      s = t ? 7'h06 : 7'h00;
`else
      s = t ? 7'h06 : 7'h3F;
`endif
      return s;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q   <= SLOT_ONES;
         div_q    <= '0;
         shadow_q <= '0;
         disp_q   <= '0;
         ready_q  <= 1'b1;
         seg_q    <= SEG_OFF;
         an_q     <= AN_OFF;
      end else begin
         slot_q   <= slot_d;
         div_q    <= div_d;
         shadow_q <= shadow_d;
         disp_q   <= disp_d;
         ready_q  <= ready_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
      end
   end

   // Outputs are encoded from the next slot/display so they move with the slot itself.
   always_comb begin
      slot_d    = slot_q;
      div_d     = div_q + DIV_W'(1);
      shadow_d  = shadow_q;
      disp_d    = disp_q;
      ready_d   = ready_q;
      digit     = 7'h00;
      an_raw    = 3'b000;
      frame_end = (slot_q == SLOT_SIGN) && (div_q == DIV_LAST);

      if (div_q == DIV_LAST) begin
         div_d = '0;
         case (slot_q)
            SLOT_ONES: slot_d = SLOT_TENS;
            SLOT_TENS: slot_d = SLOT_SIGN;
            default:   slot_d = SLOT_ONES;
         endcase
      end

      // A boundary transfer needs a full shadow, so it never coincides with a handshake.
      if (frame_end && !ready_q) begin
         disp_d  = shadow_q;
         ready_d = 1'b1;
      end else if (in_valid && ready_q) begin
         shadow_d = in_bcd;
         ready_d  = 1'b0;
      end

      case (slot_d)
         SLOT_ONES: begin
            digit  = ones_seg(disp_d[3:0]);
            an_raw = 3'b001;
         end
         SLOT_TENS: begin
            digit  = tens_seg(disp_d[4]);
            an_raw = 3'b010;
         end
         SLOT_SIGN: begin
            digit  = disp_d[5] ? 7'h40 : 7'h00;
            an_raw = 3'b100;
         end
         default: begin
            digit  = 7'h00;
            an_raw = 3'b000;
         end
      endcase

      seg_d = SEG_ACTIVE_LOW ? ~digit : digit;
      an_d  = SEG_ACTIVE_LOW ? ~an_raw : an_raw;
   end

   assign in_ready = ready_q;
   assign seg      = seg_q;
   assign an       = an_q;

endmodule
